// File: rtl/alu_share_arbiter_pkg.sv
// rtl/alu_share_arbiter_pkg.sv - shared encodings for the shared add/subtract arbiter
package alu_share_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/alu_addsub.sv
// rtl/alu_addsub.sv - combinational WIDTH+1 bit add/subtract with carry and zero flags
module alu_addsub
    import alu_share_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             zero
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   full;

    // Subtract as A + ~B + 1 so the top bit reads as "no borrow" (A >= B unsigned).
    always_comb begin
        b_eff = (op == OP_SUB) ? ~b : b;
        full  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (op == OP_SUB)};
    end

    assign sum   = full[WIDTH-1:0];
    assign carry = full[WIDTH];
    assign zero  = (full[WIDTH-1:0] == '0);

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one add/subtract datapath between two requesters
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic             req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic             req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_carry,
    output logic             resp_zero,
    output logic             busy
);

    state_t           state;
    logic             ptr;
    logic             owner;
    logic             op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;

    logic             grant_any;
    logic             grant_id;
    logic [WIDTH-1:0] alu_sum;
    logic             alu_carry;
    logic             alu_zero;

    // A lone valid requester wins outright; the pointer only breaks ties.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = REQ0;
        if (state == IDLE) begin
            if (req0_valid && req1_valid) begin
                grant_any = 1'b1;
                grant_id  = ptr;
            end else if (req0_valid) begin
                grant_any = 1'b1;
                grant_id  = REQ0;
            end else if (req1_valid) begin
                grant_any = 1'b1;
                grant_id  = REQ1;
            end
        end
    end

    assign req0_ready = grant_any && (grant_id == REQ0);
    assign req1_ready = grant_any && (grant_id == REQ1);
    assign busy       = (state != IDLE);

    alu_addsub #(
        .WIDTH (WIDTH)
    ) u_alu (
        .op    (op_r),
        .a     (a_r),
        .b     (b_r),
        .sum   (alu_sum),
        .carry (alu_carry),
        .zero  (alu_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= REQ0;
            owner       <= REQ0;
            op_r        <= 1'b0;
            a_r         <= '0;
            b_r         <= '0;
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            resp_data   <= '0;
            resp_carry  <= 1'b0;
            resp_zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        a_r   <= (grant_id == REQ1) ? req1_a  : req0_a;
                        b_r   <= (grant_id == REQ1) ? req1_b  : req0_b;
                        op_r  <= (grant_id == REQ1) ? req1_op : req0_op;
                        owner <= grant_id;
                        ptr   <= ~grant_id;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    resp_data   <= alu_sum;
                    resp_carry  <= alu_carry;
                    resp_zero   <= alu_zero;
                    resp0_valid <= (owner == REQ0);
                    resp1_valid <= (owner == REQ1);
                    state       <= RESP;
                end
                RESP: begin
                    // Only the owner's ready retires the result.
                    if ((owner == REQ0 && resp0_ready) || (owner == REQ1 && resp1_ready)) begin
                        resp0_valid <= 1'b0;
                        resp1_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - scoreboard bench for the shared add/subtract arbiter
module tb_alu_share_arbiter;

    logic        clk;
    logic        reset;
    logic        req0_valid, req0_ready, req0_op;
    logic [31:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_op;
    logic [31:0] req1_a, req1_b;
    logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
    logic [31:0] resp_data;
    logic        resp_carry, resp_zero, busy;

    typedef struct {
        logic        owner;
        logic [31:0] data;
        logic        carry;
        logic        zero;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    alu_share_arbiter #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_op     (req0_op),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_op     (req1_op),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .resp0_valid (resp0_valid),
        .resp0_ready (resp0_ready),
        .resp1_valid (resp1_valid),
        .resp1_ready (resp1_ready),
        .resp_data   (resp_data),
        .resp_carry  (resp_carry),
        .resp_zero   (resp_zero),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic owner, input logic [31:0] d, input logic c, input logic z);
        exp_t e;
        e.owner = owner;
        e.data  = d;
        e.carry = c;
        e.zero  = z;
        return e;
    endfunction

    // Monitor: pops the scoreboard on every response handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resp0_valid && resp1_valid) check("both_resp_valid", 32'd1, 32'd0);
            if (req0_ready && req1_ready) check("both_req_ready", 32'd1, 32'd0);
            if ((resp0_valid && resp0_ready) || (resp1_valid && resp1_ready)) begin
                if (q.size() == 0) begin
                    check("unexpected_resp", {31'd0, resp1_valid}, 32'hffffffff);
                end else begin
                    e = q.pop_front();
                    check("resp_owner", {31'd0, resp1_valid}, {31'd0, e.owner});
                    check("resp_data",  resp_data, e.data);
                    check("resp_carry", {31'd0, resp_carry}, {31'd0, e.carry});
                    check("resp_zero",  {31'd0, resp_zero}, {31'd0, e.zero});
                end
            end
        end
    end

    task automatic wait_grant(output int who, output int at);
        who = -1;
        for (int n = 0; n < 40 && who < 0; n++) begin
            @(negedge clk);
            if (req0_ready) who = 0;
            else if (req1_ready) who = 1;
        end
        at = cyc;
        if (who < 0) check("grant_timeout", 32'd0, 32'd1);
    endtask

    task automatic drive(input int id, input logic v, input logic op, input logic [31:0] a, input logic [31:0] b);
        if (id == 0) begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end
    endtask

    task automatic issue(input int id, input logic op, input logic [31:0] a, input logic [31:0] b,
                         input logic push, input logic [31:0] ed, input logic ec, input logic ez,
                         output int waited);
        int who, at, start;
        @(posedge clk); #1;
        drive(id, 1'b1, op, a, b);
        start = cyc;
        wait_grant(who, at);
        check("grant_id", who, id);
        if (push && who == id) q.push_back(mk(id[0], ed, ec, ez));
        waited = at - start;
        @(posedge clk); #1;
        drive(id, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic drain();
        for (int n = 0; n < 60 && (q.size() != 0 || busy); n++) @(negedge clk);
        check("drain_empty", q.size(), 32'd0);
    endtask

    initial begin
        int w, who, at, last;
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        resp0_ready = 1'b1;
        resp1_ready = 1'b1;
        #2;
        check("rst_outputs", {busy, resp0_valid, resp1_valid, resp_carry, resp_zero, req0_ready, req1_ready}, 32'd0);
        check("rst_data", resp_data, 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        // Single add with latency probe.
        issue(0, 1'b0, 32'd7, 32'd4, 1'b1, 32'd11, 1'b0, 1'b0, w);
        check("add_ready_same_cycle", w, 32'd0);
        @(negedge clk);
        check("exec_no_valid", {busy, resp0_valid}, 32'b10);
        @(negedge clk);
        check("resp0_at_n2", {resp0_valid, resp1_valid}, 32'b10);
        drain();

        // Subtract with the response held off for 5 cycles.
        resp1_ready = 1'b0;
        issue(1, 1'b1, 32'd7, 32'd4, 1'b1, 32'd3, 1'b1, 1'b0, w);
        drive(0, 1'b1, 1'b0, 32'd1, 32'd1);
        @(negedge clk);
        check("exec_req0_blocked", {busy, req0_ready}, 32'b10);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", {resp1_valid, resp0_valid, busy, req0_ready}, 32'b1010);
            check("hold_data", {resp_data[30:0], resp_carry}, {31'd3, 1'b1});
        end
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        resp1_ready = 1'b1;
        drain();

        // Contention from reset: grants alternate, 3-cycle issue interval.
        @(posedge clk); #1;
        reset = 1'b1;
        drive(0, 1'b1, 1'b0, 32'd7, 32'd4);
        drive(1, 1'b1, 1'b1, 32'd7, 32'd4);
        @(posedge clk); #1 reset = 1'b0;
        last = 0;
        for (int g = 0; g < 4; g++) begin
            wait_grant(who, at);
            if (who < 0) break;
            check("rr_order", who, g % 2);
            if (who == 0) q.push_back(mk(1'b0, 32'd11, 1'b0, 1'b0));
            else          q.push_back(mk(1'b1, 32'd3, 1'b1, 1'b0));
            if (g > 0) check("rr_interval", at - last, 32'd3);
            last = at;
            @(posedge clk);
        end
        #1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        drain();

        // Wrap-around boundaries.
        issue(0, 1'b1, 32'd0, 32'd1, 1'b1, 32'hffffffff, 1'b0, 1'b0, w);
        issue(1, 1'b0, 32'hffffffff, 32'd1, 1'b1, 32'd0, 1'b1, 1'b1, w);
        issue(0, 1'b1, 32'd5, 32'd5, 1'b1, 32'd0, 1'b1, 1'b1, w);
        issue(1, 1'b0, 32'h80000000, 32'h80000000, 1'b1, 32'd0, 1'b1, 1'b1, w);
        drain();

        // Reset during EXEC.
        issue(0, 1'b0, 32'd1, 32'd2, 1'b0, 32'd0, 1'b0, 1'b0, w);
        #1 reset = 1'b1;
        #1;
        check("rst_exec_outputs", {busy, resp0_valid, resp1_valid, resp_carry, resp_zero}, 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        // Reset during RESP with the pointer left on requester 1.
        resp0_ready = 1'b0;
        issue(0, 1'b0, 32'd7, 32'd4, 1'b0, 32'd0, 1'b0, 1'b0, w);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_resp_valid", {resp0_valid, busy}, 32'b11);
        #2 reset = 1'b1;
        #1;
        check("rst_resp_outputs", {busy, resp0_valid, resp1_valid, resp_carry, resp_zero}, 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        resp0_ready = 1'b1;

        // Pointer back on requester 0 after reset.
        drive(0, 1'b1, 1'b0, 32'd2, 32'd3);
        drive(1, 1'b1, 1'b1, 32'd9, 32'd2);
        wait_grant(who, at);
        check("post_rst_ptr", who, 32'd0);
        if (who == 0) q.push_back(mk(1'b0, 32'd5, 1'b0, 1'b0));
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        wait_grant(who, at);
        check("post_rst_second", who, 32'd1);
        if (who == 1) q.push_back(mk(1'b1, 32'd7, 1'b1, 1'b0));
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        issue(1, 1'b0, 32'd20, 32'd22, 1'b1, 32'd42, 1'b0, 1'b0, w);
        drain();

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

endmodule
